// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, single-outstanding memory reads, instruction FIFO.
// Optional FETCH_STATS_EN adds oFetchCount/oFlushCount statistics outputs.
module fetch_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iClk,
  input  logic        iRstN,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemValid,
  input  logic [31:0] iMemData,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic        oInstrValid,
  output logic [31:0] oInstr,
  output logic [31:0] oInstrPC,
  input  logic        iInstrReady,
  output logic        oBusy
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] oFetchCount,
  output logic [15:0] oFlushCount
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DISCARD
  } state_t;

  state_t        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   req_pc_q;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] count_q;

  logic        credit;
  logic        mem_req;
  logic        push;
  logic        pop;
  logic [31:0] redirect_pc;

  assign redirect_pc = iRedirectPC & ~32'h3;

  // count_q includes nothing outstanding while in ISSUE
  assign credit  = count_q < CW'(DEPTH);
  assign mem_req = (state_q == ISSUE) && credit && !iRedirect;
  assign push    = (state_q == WAIT) && iMemValid && !iRedirect;
  assign pop     = (count_q != '0) && iInstrReady && !iRedirect;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (iRedirect) begin
      pc_q    <= redirect_pc;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      unique case (state_q)
        WAIT:    state_q <= iMemValid ? ISSUE : DISCARD;
        DISCARD: state_q <= iMemValid ? ISSUE : DISCARD;
        default: state_q <= ISSUE;
      endcase
    end else begin
      if (mem_req) begin
        pc_q     <= pc_q + 32'd4;
        req_pc_q <= pc_q;
      end
      if (push) begin
        fifo_data[wr_q] <= iMemData;
        fifo_pc[wr_q]   <= req_pc_q;
        wr_q            <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      unique case (state_q)
        IDLE:    state_q <= ISSUE;
        ISSUE:   if (mem_req) state_q <= WAIT;
        WAIT:    if (iMemValid) state_q <= ISSUE;
        DISCARD: if (iMemValid) state_q <= ISSUE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oFetchCount <= '0;
      oFlushCount <= '0;
    end else begin
      if (push) begin
        oFetchCount <= oFetchCount + 32'd1;
      end
      if (iRedirect) begin
        oFlushCount <= oFlushCount + 16'd1;
      end
    end
  end
`endif

  assign oMemReq     = mem_req;
  assign oMemAddr    = mem_req ? pc_q : '0;
  assign oInstrValid = count_q != '0;
  assign oInstr      = fifo_data[rd_q];
  assign oInstrPC    = fifo_pc[rd_q];
  assign oBusy       = (state_q == WAIT) || (state_q == DISCARD);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (DEPTH=4, RESET_PC=0).
// Memory responses are driven by hand; instruction data = address ^ 32'hC0DE_0000.
module tb_fetch_sequencer;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        oMemReq;
  logic [31:0] oMemAddr;
  logic        iMemValid;
  logic [31:0] iMemData;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        oInstrValid;
  logic [31:0] oInstr;
  logic [31:0] oInstrPC;
  logic        iInstrReady;
  logic        oBusy;
`ifdef FETCH_STATS_EN
  logic [31:0] oFetchCount;
  logic [15:0] oFlushCount;
`endif

  int nchk = 0;
  int nerr = 0;

  always #5 iClk = ~iClk;

  fetch_sequencer #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .iClk(iClk),
    .iRstN(iRstN),
    .oMemReq(oMemReq),
    .oMemAddr(oMemAddr),
    .iMemValid(iMemValid),
    .iMemData(iMemData),
    .iRedirect(iRedirect),
    .iRedirectPC(iRedirectPC),
    .oInstrValid(oInstrValid),
    .oInstr(oInstr),
    .oInstrPC(oInstrPC),
    .iInstrReady(iInstrReady),
    .oBusy(oBusy)
`ifdef FETCH_STATS_EN
    ,
    .oFetchCount(oFetchCount),
    .oFlushCount(oFlushCount)
`endif
  );

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  task automatic head(input logic [31:0] a);
    chk("head_valid", 32'(oInstrValid), 32'd1);
    chk("head_pc", oInstrPC, a);
    chk("head_instr", oInstr, dat(a));
  endtask

  // Enter at negedge of an ISSUE cycle; leave at negedge after the push.
  task automatic serve(input logic [31:0] a);
    chk("req", 32'(oMemReq), 32'd1);
    chk("req_addr", oMemAddr, a);
    cyc();
    iMemValid = 1'b1;
    iMemData  = dat(a);
    @(negedge iClk);
    chk("busy_wait", 32'(oBusy), 32'd1);
    cyc();
    iMemValid = 1'b0;
    @(negedge iClk);
  endtask

  // Leaves at negedge of the first ISSUE cycle.
  task automatic do_reset();
    iRstN       = 1'b0;
    iMemValid   = 1'b0;
    iMemData    = '0;
    iRedirect   = 1'b0;
    iRedirectPC = '0;
    iInstrReady = 1'b0;
    cyc();
    cyc();
    iRstN = 1'b1;
    cyc();
    @(negedge iClk);
  endtask

  initial begin
    iRstN       = 1'b0;
    iMemValid   = 1'b0;
    iMemData    = '0;
    iRedirect   = 1'b0;
    iRedirectPC = '0;
    iInstrReady = 1'b0;
    cyc();
    chk("rst_req", 32'(oMemReq), 32'd0);
    chk("rst_addr", oMemAddr, 32'd0);
    chk("rst_valid", 32'(oInstrValid), 32'd0);
    chk("rst_instr", oInstr, 32'd0);
    chk("rst_pc", oInstrPC, 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
`ifdef FETCH_STATS_EN
    chk("rst_fetchcnt", oFetchCount, 32'd0);
    chk("rst_flushcnt", 32'(oFlushCount), 32'd0);
`endif

    // Streaming with 1-cycle memory and an always-ready consumer
    do_reset();
    iInstrReady = 1'b1;
    serve(32'h0);
    head(32'h0);
    serve(32'h4);
    head(32'h4);
    serve(32'h8);
    head(32'h8);

    // Back-pressure: credit limits outstanding+buffered to DEPTH
    do_reset();
    serve(32'h0);
    head(32'h0);
    serve(32'h4);
    serve(32'h8);
    serve(32'hC);
    chk("full_noreq", 32'(oMemReq), 32'd0);
    chk("full_busy", 32'(oBusy), 32'd0);
    cyc();
    @(negedge iClk);
    chk("full_noreq2", 32'(oMemReq), 32'd0);
    head(32'h0);
    iInstrReady = 1'b1;
    cyc();
    iInstrReady = 1'b0;
    @(negedge iClk);
    head(32'h4);
    serve(32'h10);
    chk("full_noreq3", 32'(oMemReq), 32'd0);
    iInstrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      head(32'h4 + 32'(4 * i));
      @(negedge iClk);
    end
    chk("drained_valid", 32'(oInstrValid), 32'd0);
    chk("drained_busy", 32'(oBusy), 32'd1);

    // Redirect while waiting; stale response arrives later
    do_reset();
    iInstrReady = 1'b1;
    serve(32'h0);
    head(32'h0);
    serve(32'h4);
    head(32'h4);
    chk("pre_redir_addr", oMemAddr, 32'h8);
    cyc();
    iRedirect   = 1'b1;
    iRedirectPC = 32'h103;
    @(negedge iClk);
    chk("redir_busy", 32'(oBusy), 32'd1);
    cyc();
    iRedirect = 1'b0;
    @(negedge iClk);
    chk("discard_busy", 32'(oBusy), 32'd1);
    chk("discard_req", 32'(oMemReq), 32'd0);
    chk("discard_valid", 32'(oInstrValid), 32'd0);
    cyc();
    iMemValid = 1'b1;
    iMemData  = dat(32'h8);
    @(negedge iClk);
    chk("stale_valid", 32'(oInstrValid), 32'd0);
    cyc();
    iMemValid = 1'b0;
    @(negedge iClk);
    chk("post_stale_valid", 32'(oInstrValid), 32'd0);
    serve(32'h100);
    head(32'h100);

    // Redirect coinciding with a response and a pop
    iInstrReady = 1'b0;
    chk("pre_coinc_addr", oMemAddr, 32'h104);
    cyc();
    iMemValid   = 1'b1;
    iMemData    = dat(32'h104);
    iRedirect   = 1'b1;
    iRedirectPC = 32'h200;
    iInstrReady = 1'b1;
    @(negedge iClk);
    head(32'h100);
    cyc();
    iMemValid = 1'b0;
    iRedirect = 1'b0;
    @(negedge iClk);
    chk("coinc_valid", 32'(oInstrValid), 32'd0);
    chk("coinc_busy", 32'(oBusy), 32'd0);
    serve(32'h200);
    head(32'h200);

    // Redirect in ISSUE suppresses that cycle's request; PC wrap
    iRedirect   = 1'b1;
    iRedirectPC = 32'hFFFF_FFFE;
    #1;
    chk("redir_issue_noreq", 32'(oMemReq), 32'd0);
    cyc();
    iRedirect = 1'b0;
    @(negedge iClk);
    chk("redir_issue_valid", 32'(oInstrValid), 32'd0);
    serve(32'hFFFF_FFFC);
    head(32'hFFFF_FFFC);
    serve(32'h0);
    head(32'h0);

    // Reset during WAIT, then a stray response
    cyc();
    chk("wait_busy", 32'(oBusy), 32'd1);
    iRstN = 1'b0;
    #1;
    chk("arst_busy", 32'(oBusy), 32'd0);
    chk("arst_req", 32'(oMemReq), 32'd0);
    chk("arst_valid", 32'(oInstrValid), 32'd0);
    chk("arst_instr", oInstr, 32'd0);
`ifdef FETCH_STATS_EN
    chk("arst_fetchcnt", oFetchCount, 32'd0);
    chk("arst_flushcnt", 32'(oFlushCount), 32'd0);
`endif
    cyc();
    iRstN     = 1'b1;
    iMemValid = 1'b1;
    iMemData  = 32'h1234_5678;
    @(negedge iClk);
    chk("stray_req", 32'(oMemReq), 32'd0);
    chk("stray_busy", 32'(oBusy), 32'd0);
    cyc();
    iMemValid = 1'b0;
    @(negedge iClk);
    chk("stray_valid", 32'(oInstrValid), 32'd0);
    serve(32'h0);
    head(32'h0);
`ifdef FETCH_STATS_EN
    chk("fetchcnt", oFetchCount, 32'd1);
    chk("flushcnt", 32'(oFlushCount), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
